// File: rtl/ddr3_rx_train_pkg.sv
// Shared types and helpers for the DDR3 DQ receive training slice.
// Holds the FSM state enum, error codes, default pattern, rotation check.
package ddr3_rx_train_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_COMPARE,
    S_EVAL,
    S_STEP,
    S_CHKRANGE,
    S_CENTER,
    S_SETTLE_C,
    S_SLIP_CHECK,
    S_SLIP_WAIT,
    S_DONE,
    S_ERROR
  } rx_train_state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_NO_WIN = 2'b01;
  localparam logic [1:0] ERR_SLIP   = 2'b10;

  localparam logic [7:0] DEF_PATTERN = 8'hF0;

  function automatic logic is_rotation(
    input logic [7:0] word,
    input logic [7:0] pattern
  );
    logic [7:0] r;
    logic       hit;
    r   = pattern;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (word == r) hit = 1'b1;
      r = {r[6:0], r[7]};
    end
    return hit;
  endfunction

endpackage

// File: rtl/ddr3_dq_rx_train_if.sv
// Lane bundle between the training controller and the IOD / fabric.
// master: controller side (drives delay, slip, status); slave: IOD/host.
interface ddr3_dq_rx_train_if;

  logic       TRAIN_START;
  logic [7:0] RX_DATA;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       RX_BIT_SLIP;
  logic       TRAIN_BUSY;
  logic       TRAIN_DONE;
  logic       TRAIN_ERR;
  logic [1:0] ERR_CODE;
  logic [7:0] CENTER_TAP;
  logic [7:0] RX_DATA_OUT;
  logic       RX_VALID;

  modport master (
    input  TRAIN_START,
    input  RX_DATA,
    input  DELAY_LINE_OUT_OF_RANGE,
    output DELAY_LINE_LOAD,
    output DELAY_LINE_MOVE,
    output DELAY_LINE_DIRECTION,
    output RX_BIT_SLIP,
    output TRAIN_BUSY,
    output TRAIN_DONE,
    output TRAIN_ERR,
    output ERR_CODE,
    output CENTER_TAP,
    output RX_DATA_OUT,
    output RX_VALID
  );

  modport slave (
    output TRAIN_START,
    output RX_DATA,
    output DELAY_LINE_OUT_OF_RANGE,
    input  DELAY_LINE_LOAD,
    input  DELAY_LINE_MOVE,
    input  DELAY_LINE_DIRECTION,
    input  RX_BIT_SLIP,
    input  TRAIN_BUSY,
    input  TRAIN_DONE,
    input  TRAIN_ERR,
    input  ERR_CODE,
    input  CENTER_TAP,
    input  RX_DATA_OUT,
    input  RX_VALID
  );

endinterface

// File: rtl/ddr3_rx_pattern_chk.sv
// Per-tap pattern checker: clear, then count words; pass = stable + rotation.
// Ports: clk, rst, clear, count, word[7:0] in; pass out (valid after count).
module ddr3_rx_pattern_chk
  import ddr3_rx_train_pkg::*;
#(
  parameter logic [7:0] PATTERN = DEF_PATTERN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       count,
  input  logic [7:0] word,
  output logic       pass
);

  logic [7:0] first_q, first_d;
  logic       seen_q, seen_d;
  logic       ok_q, ok_d;

  always_comb begin
    first_d = first_q;
    seen_d  = seen_q;
    ok_d    = ok_q;
    if (clear) begin
      seen_d = 1'b0;
      ok_d   = 1'b0;
    end else if (count) begin
      if (!seen_q) begin
        first_d = word;
        seen_d  = 1'b1;
        ok_d    = is_rotation(word, PATTERN);
      end else if (word != first_q) begin
        ok_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= '0;
      seen_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      first_q <= first_d;
      seen_q  <= seen_d;
      ok_q    <= ok_d;
    end
  end

  assign pass = ok_q;

endmodule

// File: rtl/ddr3_dq_rx_train.sv
// DDR3 DQ receive training: sweep delay, centre in first eye, bit-slip align.
// Ports: FAB_CLK, RX_SYNC_RST (sync, active-high); io = lane bundle (master).
module ddr3_dq_rx_train
  import ddr3_rx_train_pkg::*;
#(
  parameter logic [7:0] PATTERN        = DEF_PATTERN,
  parameter int         MAX_TAPS       = 128,
  parameter int         SETTLE_CYCLES  = 8,
  parameter int         COMPARE_CYCLES = 16,
  parameter int         MIN_WINDOW     = 4,
  parameter int         SLIP_WAIT      = 4
) (
  input logic                FAB_CLK,
  input logic                RX_SYNC_RST,
  ddr3_dq_rx_train_if.master io
);

  localparam int CNT_W = 16;

  rx_train_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0] tap_q, tap_d;
  logic [8:0] ws_q, ws_d;
  logic [8:0] wl_q, wl_d;
  logic [8:0] cen_q, cen_d;
  logic [8:0] slips_q, slips_d;

  logic load_q, load_d;
  logic move_q, move_d;
  logic dir_q, dir_d;
  logic slip_q, slip_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic terr_q, terr_d;
  logic valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic [7:0] dout_q;

  logic chk_clr;
  logic chk_cnt;
  logic chk_pass;
  logic sweep_end;

  assign chk_clr = (state_q == S_SETTLE);
  assign chk_cnt = (state_q == S_COMPARE);

  ddr3_rx_pattern_chk #(
    .PATTERN(PATTERN)
  ) u_chk (
    .clk  (FAB_CLK),
    .rst  (RX_SYNC_RST),
    .clear(chk_clr),
    .count(chk_cnt),
    .word (io.RX_DATA),
    .pass (chk_pass)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tap_d     = tap_q;
    ws_d      = ws_q;
    wl_d      = wl_q;
    cen_d     = cen_q;
    slips_d   = slips_q;
    code_d    = code_q;
    load_d    = 1'b0;
    move_d    = 1'b0;
    dir_d     = 1'b0;
    slip_d    = 1'b0;
    sweep_end = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (io.TRAIN_START) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
          tap_d   = '0;
          ws_d    = '0;
          wl_d    = '0;
          cen_d   = '0;
          slips_d = '0;
          code_d  = ERR_NONE;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_COMPARE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMPARE: begin
        if (cnt_q == CNT_W'(COMPARE_CYCLES - 1)) begin
          state_d = S_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (chk_pass) begin
          if (wl_q == '0) ws_d = tap_q;
          if (wl_q != 9'h1FF) wl_d = wl_q + 1'b1;
        end else if (wl_q >= 9'(MIN_WINDOW)) begin
          sweep_end = 1'b1;
        end else begin
          wl_d = '0;
        end
        if (tap_q == 9'(MAX_TAPS - 1)) sweep_end = 1'b1;
        if (!sweep_end) begin
          state_d = S_STEP;
          move_d  = 1'b1;
          dir_d   = 1'b1;
          tap_d   = tap_q + 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_CHKRANGE;
      end
      S_CHKRANGE: begin
        // Tap just stepped past the delay line's end: drop it unevaluated.
        if (io.DELAY_LINE_OUT_OF_RANGE) begin
          tap_d     = tap_q - 1'b1;
          sweep_end = 1'b1;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_CENTER: begin
        // One decrement every other cycle until tap reaches the centre.
        if (move_q) begin
          move_d = 1'b0;
        end else if (tap_q != cen_q) begin
          move_d = 1'b1;
          tap_d  = tap_q - 1'b1;
        end else begin
          state_d = S_SETTLE_C;
          cnt_d   = '0;
        end
      end
      S_SETTLE_C: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_SLIP_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SLIP_CHECK: begin
        if (io.RX_DATA == PATTERN) begin
          state_d = S_DONE;
        end else if (slips_q == 9'd7) begin
          state_d = S_ERROR;
          code_d  = ERR_SLIP;
        end else begin
          state_d = S_SLIP_WAIT;
          slip_d  = 1'b1;
          slips_d = slips_q + 1'b1;
          cnt_d   = '0;
        end
      end
      S_SLIP_WAIT: begin
        // First cycle carries the slip pulse, then SLIP_WAIT idle cycles.
        if (cnt_q == CNT_W'(SLIP_WAIT)) begin
          state_d = S_SLIP_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (sweep_end) begin
      if (wl_d < 9'(MIN_WINDOW)) begin
        state_d = S_ERROR;
        code_d  = ERR_NO_WIN;
      end else begin
        state_d = S_CENTER;
        cen_d   = ws_d + (wl_d >> 1);
      end
    end

    busy_d  = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    done_d  = (state_d == S_DONE);
    terr_d  = (state_d == S_ERROR);
    valid_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tap_q   <= '0;
      ws_q    <= '0;
      wl_q    <= '0;
      cen_q   <= '0;
      slips_q <= '0;
      code_q  <= ERR_NONE;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
      dir_q   <= 1'b0;
      slip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      ws_q    <= ws_d;
      wl_q    <= wl_d;
      cen_q   <= cen_d;
      slips_q <= slips_d;
      code_q  <= code_d;
      load_q  <= load_d;
      move_q  <= move_d;
      dir_q   <= dir_d;
      slip_q  <= slip_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      valid_q <= valid_d;
      dout_q  <= io.RX_DATA;
    end
  end

  assign io.DELAY_LINE_LOAD      = load_q;
  assign io.DELAY_LINE_MOVE      = move_q;
  assign io.DELAY_LINE_DIRECTION = dir_q;
  assign io.RX_BIT_SLIP          = slip_q;
  assign io.TRAIN_BUSY           = busy_q;
  assign io.TRAIN_DONE           = done_q;
  assign io.TRAIN_ERR            = terr_q;
  assign io.ERR_CODE             = code_q;
  assign io.CENTER_TAP           = cen_q[7:0];
  assign io.RX_DATA_OUT          = dout_q;
  assign io.RX_VALID             = valid_q;

endmodule
